// File: rtl/level_alarm_pkg.sv
// Shared types for the level alarm generator: FSM states, alarm codes
// and the raw classification target produced per sample.
package level_alarm_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_NORMAL = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TGT_NORMAL = 2'd0,
    TGT_LOW    = 2'd1,
    TGT_HIGH   = 2'd2,
    TGT_RANGE  = 2'd3
  } target_t;

  // Bit 2 set marks every error so the display can show a single "E".
  localparam logic [2:0] CODE_NORMAL    = 3'b000;
  localparam logic [2:0] CODE_LOW       = 3'b001;
  localparam logic [2:0] CODE_HIGH      = 3'b010;
  localparam logic [2:0] CODE_ERR_STALE = 3'b100;
  localparam logic [2:0] CODE_ERR_RANGE = 3'b101;
  localparam logic [2:0] CODE_ERR_CFG   = 3'b110;

  function automatic logic [2:0] target_code(target_t t);
    case (t)
      TGT_LOW:   return CODE_LOW;
      TGT_HIGH:  return CODE_HIGH;
      TGT_RANGE: return CODE_ERR_RANGE;
      default:   return CODE_NORMAL;
    endcase
  endfunction

  function automatic state_t target_state(target_t t);
    case (t)
      TGT_LOW:   return ST_LOW;
      TGT_HIGH:  return ST_HIGH;
      TGT_RANGE: return ST_ERROR;
      default:   return ST_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/level_alarm_gen_classify.sv
// Combinational sample classifier: range check plus hysteresis relative to
// the current alarm state.
module level_classify
  import level_alarm_pkg::*;
#(
  parameter int LEVEL_W   = 8,
  parameter int LEVEL_MAX = 250
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] low_thr,
  input  logic [LEVEL_W-1:0] high_thr,
  input  logic [LEVEL_W-1:0] hyst,
  input  logic [2:0]         state,
  output logic [1:0]         target
);

  localparam int EXT_W = LEVEL_W + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(LEVEL_MAX);

  logic [EXT_W-1:0]   level_ext;
  logic [EXT_W-1:0]   leave_low;
  logic [LEVEL_W-1:0] leave_high;

  always_comb begin
    level_ext  = {1'b0, level};
    leave_low  = {1'b0, low_thr} + {1'b0, hyst};
    leave_high = (high_thr > hyst) ? (high_thr - hyst) : '0;
  end

  // Crossing to the opposite extreme is checked before the return to
  // NORMAL so a wide hysteresis band cannot mask it.
  always_comb begin
    target = TGT_NORMAL;
    if (level_ext > MAX_EXT) begin
      target = TGT_RANGE;
    end else if (state == ST_LOW) begin
      if (level > high_thr)          target = TGT_HIGH;
      else if (level_ext >= leave_low) target = TGT_NORMAL;
      else                           target = TGT_LOW;
    end else if (state == ST_HIGH) begin
      if (level < low_thr)           target = TGT_LOW;
      else if (level <= leave_high)  target = TGT_NORMAL;
      else                           target = TGT_HIGH;
    end else begin
      if (level < low_thr)           target = TGT_LOW;
      else if (level > high_thr)     target = TGT_HIGH;
      else                           target = TGT_NORMAL;
    end
  end

endmodule

// File: rtl/level_alarm_gen.sv
// Level alarm FSM: persistence-filtered NORMAL/LOW/HIGH classification with
// stale-sensor, range and configuration error reporting.
module level_alarm_gen
  import level_alarm_pkg::*;
#(
  parameter int LEVEL_W        = 8,
  parameter int LEVEL_MAX      = 250,
  parameter int PERSIST        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  input  logic [LEVEL_W-1:0] low_thr,
  input  logic [LEVEL_W-1:0] high_thr,
  input  logic [LEVEL_W-1:0] hyst,
  output logic [2:0]         alarm_code,
  output logic               alarm_change
);

  // state  | meaning
  // INIT   | after reset, no category confirmed yet, code 000
  // NORMAL | level between thresholds
  // LOW    | level confirmed below low_thr
  // HIGH   | level confirmed above high_thr
  // ERROR  | stale / range / config fault, cause held in err_code

  localparam int CNT_W = $clog2(PERSIST + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic [2:0]       err_code, err_nxt, code_nxt;
  target_t          pend_tgt, pend_tgt_nxt, target;
  logic [1:0]       target_raw;
  logic [CNT_W-1:0] pend_cnt, pend_cnt_nxt, cnt_inc;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic             cfg_bad, timeout_hit, tgt_matches;

  level_classify #(
    .LEVEL_W   (LEVEL_W),
    .LEVEL_MAX (LEVEL_MAX)
  ) u_classify (
    .level    (level),
    .low_thr  (low_thr),
    .high_thr (high_thr),
    .hyst     (hyst),
    .state    (state),
    .target   (target_raw)
  );

  assign target  = target_t'(target_raw);
  assign cfg_bad = (low_thr >= high_thr);
  // alarm_code always mirrors the current state, so it doubles as the
  // "same category" reference; INIT never matches so it must persist out.
  assign tgt_matches = (state != ST_INIT) && (target_code(target) == alarm_code);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      err_code     <= CODE_NORMAL;
      pend_tgt     <= TGT_NORMAL;
      pend_cnt     <= '0;
      to_cnt       <= '0;
      alarm_code   <= CODE_NORMAL;
      alarm_change <= 1'b0;
    end else begin
      state        <= state_nxt;
      err_code     <= err_nxt;
      pend_tgt     <= pend_tgt_nxt;
      pend_cnt     <= pend_cnt_nxt;
      to_cnt       <= to_cnt_nxt;
      alarm_code   <= code_nxt;
      alarm_change <= (code_nxt != alarm_code);
    end
  end

  always_comb begin
    state_nxt    = state;
    err_nxt      = err_code;
    pend_tgt_nxt = pend_tgt;
    pend_cnt_nxt = pend_cnt;
    cnt_inc      = '0;

    if (level_valid)          to_cnt_nxt = '0;
    else if (to_cnt != TO_MAX) to_cnt_nxt = to_cnt + 1'b1;
    else                      to_cnt_nxt = to_cnt;
    timeout_hit = !level_valid && (to_cnt_nxt == TO_MAX);

    if (cfg_bad) begin
      state_nxt    = ST_ERROR;
      err_nxt      = CODE_ERR_CFG;
      pend_cnt_nxt = '0;
    end else if (timeout_hit) begin
      state_nxt    = ST_ERROR;
      err_nxt      = CODE_ERR_STALE;
      pend_cnt_nxt = '0;
    end else if (level_valid) begin
      if (tgt_matches) begin
        pend_cnt_nxt = '0;
      end else begin
        cnt_inc = (target == pend_tgt && pend_cnt != '0) ? pend_cnt + 1'b1
                                                         : CNT_W'(1);
        if (cnt_inc == PERSIST_C) begin
          state_nxt    = target_state(target);
          pend_cnt_nxt = '0;
          if (target == TGT_RANGE) err_nxt = CODE_ERR_RANGE;
        end else begin
          pend_tgt_nxt = target;
          pend_cnt_nxt = cnt_inc;
        end
      end
    end
  end

  always_comb begin
    case (state_nxt)
      ST_LOW:   code_nxt = CODE_LOW;
      ST_HIGH:  code_nxt = CODE_HIGH;
      ST_ERROR: code_nxt = err_nxt;
      default:  code_nxt = CODE_NORMAL;
    endcase
  end

endmodule
